// File: rtl/fp_result_stage_pkg.sv
// ---------------------------------------------------------------------------
// fp_result_stage_pkg : shared RISC-V FP types (fflags, rounding modes)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fp_result_stage_pkg;

  // Exception flags ordered {NV, DZ, OF, UF, NX}
  typedef logic [4:0] fflags_t;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4,
    DYN = 3'd7
  } rounding_mode_e;

  function automatic logic rm_reserved(input logic [2:0] rm);
    return rm inside {3'd5, 3'd6, 3'd7};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp_skid_buffer.sv
// ---------------------------------------------------------------------------
// fp_skid_buffer : 2-entry valid/ready FIFO with registered in_ready
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fp_skid_buffer #(
  parameter int ENTRY_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ENTRY_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ENTRY_W-1:0] out_data
);

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  logic [1:0]         occ_q, occ_d;
  logic               in_ready_q, in_ready_d;
  logic [ENTRY_W-1:0] head_q, head_d;
  logic [ENTRY_W-1:0] tail_q, tail_d;
  logic               push;
  logic               pop;

  assign push      = in_valid && in_ready_q;
  assign out_valid = (occ_q != OCC_EMPTY);
  assign pop       = out_valid && out_ready;
  assign in_ready  = in_ready_q;
  assign out_data  = head_q;

  // Head always lives in head_q; vacated slots are zeroed so idle outputs read 0.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    if (flush) begin
      occ_d  = OCC_EMPTY;
      head_d = '0;
      tail_d = '0;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (push) begin
            occ_d  = OCC_ONE;
            head_d = in_data;
          end
        end
        OCC_ONE: begin
          if (push && pop) begin
            head_d = in_data;
          end else if (push) begin
            occ_d  = OCC_FULL;
            tail_d = in_data;
          end else if (pop) begin
            occ_d  = OCC_EMPTY;
            head_d = '0;
          end
        end
        OCC_FULL: begin
          if (pop) begin
            occ_d  = OCC_ONE;
            head_d = tail_q;
            tail_d = '0;
          end
        end
        default: begin
          occ_d  = OCC_EMPTY;
          head_d = '0;
          tail_d = '0;
        end
      endcase
    end
    in_ready_d = (occ_d != OCC_FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      occ_q      <= OCC_EMPTY;
      in_ready_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      occ_q      <= occ_d;
      in_ready_q <= in_ready_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp_result_stage.sv
// ---------------------------------------------------------------------------
// fp_result_stage : FP result skid buffer, fcsr (fflags/frm) and rm resolution
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fp_result_stage
  import fp_result_stage_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      inValid,
  output logic                      inReady,
  input  logic [WIDTH-1:0]          inResult,
  input  fflags_t                   inFlags,
  input  logic [REG_ADDR_WIDTH-1:0] inRd,
  output logic                      outValid,
  input  logic                      outReady,
  output logic [WIDTH-1:0]          outResult,
  output logic [REG_ADDR_WIDTH-1:0] outRd,
  input  logic                      flush,
  input  logic [2:0]                instrRm,
  output logic [2:0]                effectiveRm,
  output logic                      rmIllegal,
  input  logic                      csrFflagsWe,
  input  logic [4:0]                csrFflagsWdata,
  input  logic                      csrFrmWe,
  input  logic [2:0]                csrFrmWdata,
  output logic [4:0]                fflags,
  output logic [2:0]                frm
);

  typedef struct packed {
    logic [WIDTH-1:0]          result;
    fflags_t                   flags;
    logic [REG_ADDR_WIDTH-1:0] rd;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  entry_t  in_entry;
  entry_t  head;
  logic [ENTRY_W-1:0] head_bits;
  logic    retire;
  fflags_t fflags_q, fflags_d;
  logic [2:0] frm_q, frm_d;

  assign in_entry = '{result: inResult, flags: inFlags, rd: inRd};

  fp_skid_buffer #(
    .ENTRY_W (ENTRY_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .in_data   (in_entry),
    .out_valid (outValid),
    .out_ready (outReady),
    .out_data  (head_bits)
  );

  assign head      = entry_t'(head_bits);
  assign outResult = head.result;
  assign outRd     = head.rd;
  assign retire    = outValid && outReady;

  // A CSR write replaces the old value but a same-cycle retirement still ORs in.
  always_comb begin
    fflags_d = csrFflagsWe ? csrFflagsWdata : fflags_q;
    if (retire && !flush) begin
      fflags_d = fflags_d | head.flags;
    end
    frm_d = csrFrmWe ? csrFrmWdata : frm_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fflags_q <= '0;
      frm_q    <= RNE;
    end else begin
      fflags_q <= fflags_d;
      frm_q    <= frm_d;
    end
  end

  assign fflags      = fflags_q;
  assign frm         = frm_q;
  assign effectiveRm = (instrRm == DYN) ? frm_q : instrRm;
  assign rmIllegal   = rm_reserved(effectiveRm);

endmodule

`default_nettype wire

// File: tb/tb_fp_result_stage.sv
// ---------------------------------------------------------------------------
// tb_fp_result_stage : directed self-checking bench for fp_result_stage
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fp_result_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        inValid;
  logic        inReady;
  logic [31:0] inResult;
  logic [4:0]  inFlags;
  logic [4:0]  inRd;
  logic        outValid;
  logic        outReady;
  logic [31:0] outResult;
  logic [4:0]  outRd;
  logic        flush;
  logic [2:0]  instrRm;
  logic [2:0]  effectiveRm;
  logic        rmIllegal;
  logic        csrFflagsWe;
  logic [4:0]  csrFflagsWdata;
  logic        csrFrmWe;
  logic [2:0]  csrFrmWdata;
  logic [4:0]  fflags;
  logic [2:0]  frm;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_result_stage #(.WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .inValid(inValid), .inReady(inReady), .inResult(inResult), .inFlags(inFlags), .inRd(inRd),
    .outValid(outValid), .outReady(outReady), .outResult(outResult), .outRd(outRd),
    .flush(flush), .instrRm(instrRm), .effectiveRm(effectiveRm), .rmIllegal(rmIllegal),
    .csrFflagsWe(csrFflagsWe), .csrFflagsWdata(csrFflagsWdata),
    .csrFrmWe(csrFrmWe), .csrFrmWdata(csrFrmWdata),
    .fflags(fflags), .frm(frm)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_fflags();
    csrFflagsWe = 1'b1; csrFflagsWdata = 5'b0;
    tick();
    csrFflagsWe = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; inValid = 1'b0; inResult = '0; inFlags = '0; inRd = '0;
    outReady = 1'b0; flush = 1'b0; instrRm = 3'd0;
    csrFflagsWe = 1'b0; csrFflagsWdata = '0; csrFrmWe = 1'b0; csrFrmWdata = '0;
    @(negedge clk);
    tick(); tick();
    checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL reset_inReady: got %b want 0", inReady); end
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL reset_outValid: got %b want 0", outValid); end
    checks++; if (fflags !== 5'b0) begin errors++; $display("FAIL reset_fflags: got %b want 00000", fflags); end
    checks++; if (frm !== 3'd0) begin errors++; $display("FAIL reset_frm: got %0d want 0", frm); end
    rst = 1'b1;
    tick();
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL release_inReady: got %b want 1", inReady); end
  endtask

  task automatic test_single_pass();
    outReady = 1'b1;
    inValid = 1'b1; inResult = 32'h3F80_0000; inFlags = 5'b00001; inRd = 5'd3;
    tick();
    inValid = 1'b0;
    checks++; if (outValid !== 1'b1) begin errors++; $display("FAIL single_outValid: got %b want 1", outValid); end
    checks++; if (outResult !== 32'h3F80_0000) begin errors++; $display("FAIL single_outResult: got %h want 3f800000", outResult); end
    checks++; if (outRd !== 5'd3) begin errors++; $display("FAIL single_outRd: got %0d want 3", outRd); end
    checks++; if (fflags !== 5'b00000) begin errors++; $display("FAIL single_fflags_early: got %b want 00000", fflags); end
    tick();
    checks++; if (fflags !== 5'b00001) begin errors++; $display("FAIL single_fflags: got %b want 00001", fflags); end
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL single_drained: got %b want 0", outValid); end
    checks++; if (outResult !== 32'h0) begin errors++; $display("FAIL single_idle_result: got %h want 0", outResult); end
  endtask

  task automatic test_backpressure();
    clear_fflags();
    outReady = 1'b0;
    inValid = 1'b1; inResult = 32'hAAAA_0001; inFlags = 5'b10000; inRd = 5'd1;
    tick();
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL bp_ready_after1: got %b want 1", inReady); end
    inResult = 32'hBBBB_0002; inFlags = 5'b01000; inRd = 5'd2;
    tick();
    checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL bp_ready_after2: got %b want 0", inReady); end
    inResult = 32'hCCCC_0003; inFlags = 5'b00100; inRd = 5'd4;
    tick();
    inValid = 1'b0;
    checks++; if (outResult !== 32'hAAAA_0001 || outRd !== 5'd1) begin errors++; $display("FAIL bp_stall_head: got %h/%0d want aaaa0001/1", outResult, outRd); end
    tick();
    checks++; if (outResult !== 32'hAAAA_0001 || outValid !== 1'b1) begin errors++; $display("FAIL bp_stable: got %h v%b want aaaa0001 v1", outResult, outValid); end
    outReady = 1'b1;
    tick();
    checks++; if (outResult !== 32'hBBBB_0002 || outRd !== 5'd2) begin errors++; $display("FAIL bp_drain2: got %h/%0d want bbbb0002/2", outResult, outRd); end
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL bp_ready_reopen: got %b want 1", inReady); end
    tick();
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0 (third offer must be dropped)", outValid); end
    checks++; if (fflags !== 5'b11000) begin errors++; $display("FAIL bp_fflags: got %b want 11000", fflags); end
  endtask

  task automatic test_flag_accum();
    clear_fflags();
    outReady = 1'b1;
    inValid = 1'b1; inResult = 32'h1; inFlags = 5'b10000; inRd = 5'd5;
    tick();
    inResult = 32'h2; inFlags = 5'b00100; inRd = 5'd6;
    tick();
    inValid = 1'b0;
    tick();
    checks++; if (fflags !== 5'b10100) begin errors++; $display("FAIL accum_nv_of: got %b want 10100", fflags); end
    inValid = 1'b1; inResult = 32'h3; inFlags = 5'b00001; inRd = 5'd7;
    tick();
    inValid = 1'b0;
    csrFflagsWe = 1'b1; csrFflagsWdata = 5'b00000;
    tick();
    csrFflagsWe = 1'b0;
    checks++; if (fflags !== 5'b00001) begin errors++; $display("FAIL accum_csr_retire: got %b want 00001", fflags); end
  endtask

  task automatic test_flush();
    outReady = 1'b0;
    inValid = 1'b1; inResult = 32'hF1; inFlags = 5'b10000; inRd = 5'd8;
    tick();
    inResult = 32'hF2; inFlags = 5'b01000; inRd = 5'd9;
    tick();
    inValid = 1'b0;
    checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL flush_full: got %b want 0", inReady); end
    flush = 1'b1; outReady = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL flush_outValid: got %b want 0", outValid); end
    checks++; if (fflags !== 5'b00001) begin errors++; $display("FAIL flush_fflags: got %b want 00001", fflags); end
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL flush_inReady: got %b want 1", inReady); end
    inValid = 1'b1; inResult = 32'hF3; inFlags = 5'b00010; flush = 1'b1;
    tick();
    inValid = 1'b0; flush = 1'b0;
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL flush_drop_accept: got %b want 0", outValid); end
  endtask

  task automatic test_rounding();
    csrFrmWe = 1'b1; csrFrmWdata = 3'd2;
    tick();
    csrFrmWe = 1'b0;
    instrRm = 3'd7; #1;
    checks++; if (effectiveRm !== 3'd2 || rmIllegal !== 1'b0) begin errors++; $display("FAIL rm_dyn2: got %0d/%b want 2/0", effectiveRm, rmIllegal); end
    checks++; if (frm !== 3'd2) begin errors++; $display("FAIL rm_frm2: got %0d want 2", frm); end
    @(negedge clk);
    csrFrmWe = 1'b1; csrFrmWdata = 3'd5;
    tick();
    csrFrmWe = 1'b0; #1;
    checks++; if (effectiveRm !== 3'd5 || rmIllegal !== 1'b1) begin errors++; $display("FAIL rm_dyn5: got %0d/%b want 5/1", effectiveRm, rmIllegal); end
    instrRm = 3'd1; #1;
    checks++; if (effectiveRm !== 3'd1 || rmIllegal !== 1'b0) begin errors++; $display("FAIL rm_static1: got %0d/%b want 1/0", effectiveRm, rmIllegal); end
    instrRm = 3'd4; #1;
    checks++; if (effectiveRm !== 3'd4 || rmIllegal !== 1'b0) begin errors++; $display("FAIL rm_static4: got %0d/%b want 4/0", effectiveRm, rmIllegal); end
    instrRm = 3'd6; #1;
    checks++; if (effectiveRm !== 3'd6 || rmIllegal !== 1'b1) begin errors++; $display("FAIL rm_static6: got %0d/%b want 6/1", effectiveRm, rmIllegal); end
    instrRm = 3'd0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [4];
    vals[0] = 32'h4000_0000; vals[1] = 32'h4040_0000; vals[2] = 32'h4080_0000; vals[3] = 32'h40A0_0000;
    outReady = 1'b1; inFlags = 5'b0;
    for (int i = 0; i < 4; i++) begin
      inValid = 1'b1; inResult = vals[i]; inRd = 5'(10 + i);
      tick();
      checks++;
      if (outValid !== 1'b1 || outResult !== vals[i] || outRd !== 5'(10 + i) || inReady !== 1'b1) begin
        errors++;
        $display("FAIL b2b_%0d: got v%b %h/%0d rdy%b want v1 %h/%0d rdy1", i, outValid, outResult, outRd, inReady, vals[i], 10 + i);
      end
    end
    inValid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    outReady = 1'b0;
    inValid = 1'b1; inResult = 32'hDEAD_0001; inFlags = 5'b00010; inRd = 5'd1;
    tick();
    inResult = 32'hDEAD_0002; inRd = 5'd2;
    csrFflagsWe = 1'b1; csrFflagsWdata = 5'b11111; csrFrmWe = 1'b1; csrFrmWdata = 3'd3;
    tick();
    inValid = 1'b0; csrFflagsWe = 1'b0; csrFrmWe = 1'b0;
    checks++; if (fflags !== 5'b11111 || frm !== 3'd3) begin errors++; $display("FAIL rstmid_pre: got %b/%0d want 11111/3", fflags, frm); end
    rst = 1'b0; outReady = 1'b1;
    tick();
    checks++; if (outValid !== 1'b0 || outResult !== 32'h0) begin errors++; $display("FAIL rstmid_out: got v%b %h want v0 0", outValid, outResult); end
    checks++; if (fflags !== 5'b0 || frm !== 3'd0) begin errors++; $display("FAIL rstmid_fcsr: got %b/%0d want 00000/0", fflags, frm); end
    checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL rstmid_inReady: got %b want 0", inReady); end
    rst = 1'b1;
    tick();
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL rstmid_release: got %b want 1", inReady); end
    checks++; if (fflags !== 5'b0) begin errors++; $display("FAIL rstmid_noaccum: got %b want 00000", fflags); end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_backpressure();
    test_flag_accum();
    test_flush();
    test_rounding();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
